// File: rtl/ram_page_streamer_if.sv
// Bus bundle between the page streamer, the RAM controller read port and the
// character-LCD writer.
//
// Character handshake: the streamer (master) raises char_valid and holds
// char_data/char_row/char_col stable until a rising clk edge where both
// char_valid and char_ready are high; that edge transfers exactly one
// character. char_ready may change freely while char_valid is low.
interface ram_page_streamer_if;
  logic [1:0] ram_sel;
  logic [3:0] ram_menu_sel;
  logic [4:0] ram_addr;
  logic [7:0] ram_dout;
  logic [7:0] char_data;
  logic       char_row;
  logic [3:0] char_col;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output ram_sel, ram_menu_sel, ram_addr,
    output char_data, char_row, char_col, char_valid,
    input  ram_dout, char_ready
  );

  modport slave (
    input  ram_sel, ram_menu_sel, ram_addr,
    input  char_data, char_row, char_col, char_valid,
    output ram_dout, char_ready
  );
endinterface

// File: rtl/ram_page_streamer.sv
// Walks one display page through the RAM controller's registered read port
// and streams each byte to the LCD writer with its row/column position.
// Blank cells are replaced by a space before they leave the block.
module ram_page_streamer #(
  parameter logic [7:0] BLANK_CODE = 8'hFE,
  parameter logic [7:0] SPACE_CODE = 8'h20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 page_sel,
  input  logic [3:0]                 menu_sel,
  ram_page_streamer_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 dbgState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [1:0] ramSel;
  logic [3:0] ramMenuSel;
  logic [4:0] ramAddr;
  logic [4:0] lastAddr;
  logic [7:0] charData;
  logic       charRow;
  logic [3:0] charCol;
  logic       errQ;
  logic       startOk;
  logic       startBad;
  logic       accept;

  // abort in IDLE drops a coincident start; abort in SEND beats acceptance
  assign startOk  = (state == IDLE) && start && !abort && (page_sel != 2'd3);
  assign startBad = (state == IDLE) && start && !abort && (page_sel == 2'd3);
  assign accept   = (state == SEND) && bus.char_ready && !abort;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state decode; abort from any busy state returns to IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startOk) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    stateNext = SEND;
      SEND:    if (bus.char_ready) stateNext = (ramAddr == lastAddr) ? FINISH : ISSUE;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (abort && (state != IDLE)) stateNext = IDLE;
  end

  // Page selection, address walk, character capture and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ramSel     <= 2'd0;
      ramMenuSel <= 4'd0;
      ramAddr    <= 5'd0;
      lastAddr   <= 5'd0;
      charData   <= 8'h00;
      charRow    <= 1'b0;
      charCol    <= 4'd0;
      errQ       <= 1'b0;
    end else begin
      errQ <= startBad;
      if (startOk) begin
        ramSel     <= page_sel;
        ramMenuSel <= menu_sel;
        ramAddr    <= 5'd0;
        // menu ROM rows are a single LCD line; RAM pages fill both lines
        lastAddr   <= (page_sel == 2'd0) ? 5'd15 : 5'd31;
      end
      if (state == WAIT) begin
        charData <= (bus.ram_dout == BLANK_CODE) ? SPACE_CODE : bus.ram_dout;
        charRow  <= ramAddr[4];
        charCol  <= ramAddr[3:0];
      end
      if (accept && (ramAddr != lastAddr)) ramAddr <= ramAddr + 5'd1;
    end
  end

  assign bus.ram_sel      = ramSel;
  assign bus.ram_menu_sel = ramMenuSel;
  assign bus.ram_addr     = ramAddr;
  assign bus.char_data    = charData;
  assign bus.char_row     = charRow;
  assign bus.char_col     = charCol;
  assign bus.char_valid   = (state == SEND);
  assign busy             = (state != IDLE);
  assign done             = (state == FINISH);
  assign err              = errQ;
  assign dbgState         = state;

endmodule

// File: tb/tb_ram_page_streamer.sv
// Directed bench for ram_page_streamer: a small RAM/ROM model behind a
// registered read port, an LCD-side handshake driver and an expected queue.
module tb_ram_page_streamer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] page_sel;
  logic [3:0] menu_sel;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  ram_page_streamer_if bus_if ();

  ram_page_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .page_sel (page_sel),
    .menu_sel (menu_sel),
    .bus      (bus_if),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dbgState (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // page contents: menu row 0 reads "MAIN MENU" followed by blank cells
  function automatic logic [7:0] ram_byte(input logic [1:0] sel, input logic [3:0] menu,
                                          input logic [4:0] addr);
    logic [7:0] txt [0:8];
    txt = '{8'h4D, 8'h41, 8'h49, 8'h4E, 8'h20, 8'h4D, 8'h45, 8'h4E, 8'h55};
    case (sel)
      2'd0: begin
        if (menu != 4'd0)   return 8'h30 + {4'd0, addr[3:0]};
        else if (addr < 9)  return txt[addr];
        else                return 8'hFE;
      end
      2'd1:    return (addr == 5'd5) ? 8'hFE : (8'hA0 + {3'd0, addr});
      2'd2:    return 8'h40 + {3'd0, addr};
      default: return 8'h00;
    endcase
  endfunction

  // controller read port: one cycle of latency
  always @(posedge clk)
    bus_if.ram_dout <= ram_byte(bus_if.ram_sel, bus_if.ram_menu_sel, bus_if.ram_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, dbg_state, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_valid"}, bus_if.char_valid, 0);
    check_eq({tag, "_data"}, bus_if.char_data, 8'h00);
    check_eq({tag, "_row"}, bus_if.char_row, 0);
    check_eq({tag, "_col"}, bus_if.char_col, 0);
    check_eq({tag, "_sel"}, bus_if.ram_sel, 0);
    check_eq({tag, "_msel"}, bus_if.ram_menu_sel, 0);
    check_eq({tag, "_addr"}, bus_if.ram_addr, 0);
  endtask

  // Drive one start and consume the page; optional stall, abort, busy starts.
  task automatic run_page(input logic [1:0] psel, input logic [3:0] msel, input int len,
                          input int stall_idx, input int abort_idx, input bit busy_starts);
    int idx = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int max_addr = 0;
    int done_seen = 0;
    bit fin = 0;
    logic [7:0] e;
    logic [7:0] hold_data;
    logic [3:0] hold_col;
    logic [4:0] hold_addr;
    @(negedge clk);
    start = 1'b1; page_sel = psel; menu_sel = msel;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      bus_if.char_ready = 1'b1;
      if (cyc == 1) begin
        // change selects so the latched copy is what gets checked
        page_sel = 2'd3; menu_sel = 4'hF;
        check_eq("busy_rise", busy, 1);
        check_eq("issue_state", dbg_state, 1);
        check_eq("latched_sel", bus_if.ram_sel, psel);
        check_eq("latched_msel", bus_if.ram_menu_sel, msel);
        check_eq("first_addr", bus_if.ram_addr, 0);
      end
      if (busy_starts && (cyc == 11 || cyc == 51)) check_eq("err_while_busy", err, 0);
      if (busy_starts && (cyc == 10 || cyc == 50)) start = 1'b1;
      if (busy && int'(bus_if.ram_addr) > max_addr) max_addr = int'(bus_if.ram_addr);
      if (bus_if.char_valid) begin
        if (idx == stall_idx && stall_cnt < 5) begin
          if (stall_cnt == 0) begin
            hold_data = bus_if.char_data; hold_col = bus_if.char_col; hold_addr = bus_if.ram_addr;
          end else begin
            check_eq("stall_data", bus_if.char_data, hold_data);
            check_eq("stall_col", bus_if.char_col, hold_col);
            check_eq("stall_addr", bus_if.ram_addr, hold_addr);
          end
          bus_if.char_ready = 1'b0;
          stall_cnt++;
        end else if (idx == abort_idx) begin
          abort = 1'b1;
          fin = 1'b1;
        end else begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
          check_eq($sformatf("data%0d", idx), bus_if.char_data, e);
          check_eq($sformatf("row%0d", idx), bus_if.char_row, (idx >= 16) ? 1 : 0);
          check_eq($sformatf("col%0d", idx), bus_if.char_col, idx % 16);
          idx++;
        end
      end
      if (done) begin
        check_eq("done_cycle", cyc, 3 * len + 1 + ((stall_idx >= 0) ? 5 : 0));
        check_eq("char_count", idx, len);
        check_eq("max_addr", max_addr, len - 1);
        fin = 1'b1;
        @(negedge clk);
        check_eq("busy_fall", busy, 0);
      end
    end
    if (!fin) check_eq("page_timeout", 0, 1);
    if (abort_idx >= 0) begin
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_valid", bus_if.char_valid, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_state", dbg_state, 0);
      for (int i = 0; i < 6; i++) begin
        if (done) done_seen++;
        @(negedge clk);
      end
      check_eq("abort_no_done", done_seen, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; page_sel = 2'd0; menu_sel = 4'd0;
    bus_if.char_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // local RAM page, ready tied high, busy-time starts ignored
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h40 + 8'(i));
    run_page(2'd2, 4'd0, 32, -1, -1, 1'b1);

    // menu row 0: blanks come out as spaces, one line only
    exp_q = '{8'h4D, 8'h41, 8'h49, 8'h4E, 8'h20, 8'h4D, 8'h45, 8'h4E, 8'h55,
              8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    run_page(2'd0, 4'd0, 16, -1, -1, 1'b0);

    // remote RAM with a 5-cycle stall on character 3, blank at address 5
    for (int i = 0; i < 32; i++) exp_q.push_back((i == 5) ? 8'h20 : (8'hA0 + 8'(i)));
    run_page(2'd1, 4'd7, 32, 3, -1, 1'b0);

    // abort on character 10 with ready high, then a clean restart
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h40 + 8'(i));
    run_page(2'd2, 4'd0, 32, -1, 10, 1'b0);
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h40 + 8'(i));
    run_page(2'd2, 4'd0, 32, -1, -1, 1'b0);

    // invalid page select
    @(negedge clk);
    start = 1'b1; page_sel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    check_eq("err_pulse", err, 1);
    check_eq("err_busy", busy, 0);
    @(negedge clk);
    check_eq("err_drop", err, 0);
    check_eq("err_busy2", busy, 0);

    // start together with abort in IDLE
    start = 1'b1; abort = 1'b1; page_sel = 2'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);

    // reset in the middle of a page
    start = 1'b1; page_sel = 2'd2; menu_sel = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_page_streamer.md
# ram_page_streamer

Read-side client of the I2C RAM controller's multiplexed display port. On a start request it walks one page (menu ROM row, remote RAM or local RAM), pulls each byte through the controller's registered read port, and hands the characters one at a time to the character-LCD writer over a valid/ready handshake. It also supplies the row/column position and substitutes blank codes. It sits between the menu controller, which issues start, and the LCD driver.

## Interface
- `BLANK_CODE`, default 8'hFE: stored byte that means "blank cell".
- `SPACE_CODE`, default 8'h20: byte emitted in place of `BLANK_CODE`.
- `clk` in 1: sole clock, all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a page transfer; sampled only in IDLE.
- `abort` in 1: cancel the transfer in progress.
- `page_sel` in 2: 0 = menu ROM, 1 = remote RAM, 2 = local RAM, 3 = invalid.
- `menu_sel` in 4: menu ROM row; used when `page_sel` = 0.
- `ram_sel` out 2: drives controller RAM select.
- `ram_menu_sel` out 4: drives controller menu select.
- `ram_addr` out 5: drives controller address.
- `ram_dout` in 8: controller data out, registered, 1-cycle latency.
- `char_data` out 8: character to LCD writer.
- `char_row` out 1: 0 = top line (addr 0–15), 1 = bottom line (addr 16–31).
- `char_col` out 4: column, equal to `ram_addr[3:0]` of the character.
- `char_valid` out 1: character offered.
- `char_ready` in 1: LCD writer accepts when high together with `char_valid`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last character is accepted.
- `err` out 1: one-cycle pulse when start is issued with `page_sel` = 3.

## Operation
- States: IDLE, ISSUE, WAIT, SEND, FINISH.
- IDLE:
  - `start`=1 with `page_sel`≤2: latch `page_sel` into `ram_sel` and `menu_sel` into `ram_menu_sel`; set `ram_addr`=0; load the page length (16 for menu, 32 otherwise); go to ISSUE.
  - `start`=1 with `page_sel`=3: pulse `err` next cycle and stay in IDLE.
- ISSUE: address is presented to the controller. Always go to WAIT.
- WAIT: `ram_dout` is valid for the issued address. Capture it into `char_data`, replacing it with `SPACE_CODE` if it equals `BLANK_CODE`. Set `char_row`=`ram_addr[4]` and `char_col`=`ram_addr[3:0]`. Go to SEND.
- SEND: `char_valid`=1 and `char_data`, `char_row`, `char_col` are held stable until `char_valid`&&`char_ready`. On acceptance:
  - if `ram_addr` = length−1, go to FINISH;
  - otherwise increment `ram_addr` and go to ISSUE.
- FINISH: `done`=1 for exactly one cycle, then IDLE.
- `ram_sel`, `ram_menu_sel` and `ram_addr` are held constant from ISSUE through the end of SEND.
- `abort`=1 in any non-IDLE state: next state is IDLE. `char_valid` drops next cycle, no `done`. `abort` has priority over handshake acceptance in the same cycle; that character counts as not accepted.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `abort` wins and the start is dropped.
- Address never wraps. Menu pages stop at 15, so addresses 16–31 are never issued for the menu ROM.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `char_valid`, `char_row` = 0; `char_data`=8'h00; `char_col`=0; `ram_sel`=0; `ram_menu_sel`=0; `ram_addr`=0.
- `rst_n` low during a transfer aborts it in the same edge, with no `done`.
- Start sampled at edge T: ISSUE in T+1, WAIT in T+2, first `char_valid` in T+3.
- Minimum 3 cycles per character with `char_ready` tied high. A 32-character page goes from start to `done` in 3·32+1 cycles, with `done` high in cycle T+97.
- `busy` rises the cycle after start and falls in the cycle after `done`.
- `err` is high in T+1 only; `busy` stays 0.

## Test plan
- Local RAM preloaded with 8'h40+i at address i, `char_ready`=1, start `page_sel`=2 → 32 characters 8'h40..8'h5F; rows 0 then 1; cols 0–15 twice; `done` at T+97.
- Menu page, `menu_sel`=0 → 16 characters "MAIN MENU" padded; every 8'hFE cell emitted as 8'h20; row 0 only; `ram_addr` never exceeds 15.
- `char_ready` low for 5 cycles on character 3 → `char_data`, `char_col` and `ram_addr` stable throughout; no duplicated or skipped characters.
- `abort` asserted in SEND of character 10 together with `char_ready`=1 → IDLE next cycle, `char_valid`=0, no `done`; a fresh start restarts at address 0.
- `page_sel`=3 start → `err` pulse at T+1, `busy` stays 0; `start` pulses while busy are ignored and the page completes normally.
- `rst_n` low mid-page → all outputs at reset values on the next edge.
